// File: rtl/mod7_operand_feeder_pkg.sv
// Shared definitions for the mod-7 reducer operand feeder: FSM encoding and default geometry.
package mod7_operand_feeder_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    GAP,
    LOAD,
    FEED,
    WAIT,
    RESULT
  } feeder_state_t;

  localparam int CW_DEF  = 6;
  localparam int NCH_DEF = 8;

endpackage

// File: rtl/mod7_operand_feeder.sv
// Sequences one wide operand into the serial mod-7 reducer as MSB-first chunks and
// returns the reducer's remainder on a valid/ready result port.
module mod7_operand_feeder
  import mod7_operand_feeder_pkg::*;
#(
  parameter int CW  = CW_DEF,
  parameter int NCH = NCH_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [CW*NCH-1:0] in_data,
  output logic              in_ready,
  input  logic              ss_ready,
  input  logic [2:0]        ss_rem,
  output logic              ss_start,
  output logic [CW-1:0]     ss_bus,
  output logic              res_valid,
  output logic [2:0]        res_rem,
  input  logic              res_ready
);

  localparam int OW   = CW * NCH;
  localparam int CNTW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [CNTW-1:0] CNT_LAST = CNTW'(NCH - 1);

  feeder_state_t   state, state_nx;
  logic [OW-1:0]   sr;
  logic [CNTW-1:0] cnt;
  logic            accept;

  // Outputs decode straight from state so reset clears them without waiting for a clock.
  assign in_ready  = (state == IDLE) & ss_ready;
  assign accept    = in_valid & in_ready;
  assign ss_start  = (state == START);
  assign ss_bus    = (state == FEED) ? sr[OW-1 -: CW] : '0;
  assign res_valid = (state == RESULT);

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = START;
      START:   state_nx = GAP;
      GAP:     state_nx = LOAD;
      LOAD:    state_nx = FEED;
      FEED:    if (cnt == CNT_LAST) state_nx = WAIT;
      WAIT:    state_nx = RESULT;
      RESULT:  if (res_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      sr      <= '0;
      cnt     <= '0;
      res_rem <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && accept) begin
        sr  <= in_data;
        cnt <= '0;
      end else if (state == FEED) begin
        sr <= sr << CW;
        // Hold at the last index so the counter never wraps on the FEED exit cycle.
        if (cnt != CNT_LAST) cnt <= cnt + 1'b1;
      end
      if (state == WAIT) res_rem <= ss_rem;
    end
  end

endmodule

// File: tb/tb_mod7_operand_feeder.sv
// Directed bench for mod7_operand_feeder, with a behavioural serial mod-7 reducer on the ss_* side.
module tb_mod7_operand_feeder;

  localparam int CW  = 6;
  localparam int NCH = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic [CW*NCH-1:0] in_data;
  logic              in_ready;
  logic              ss_ready;
  logic [2:0]        ss_rem;
  logic              ss_start;
  logic [CW-1:0]     ss_bus;
  logic              res_valid;
  logic [2:0]        res_rem;
  logic              res_ready;

  int checks   = 0;
  int failures = 0;
  logic [CW-1:0] obs_bus [NCH];

  mod7_operand_feeder #(.CW(CW), .NCH(NCH)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .ss_ready(ss_ready), .ss_rem(ss_rem), .ss_start(ss_start), .ss_bus(ss_bus),
    .res_valid(res_valid), .res_rem(res_rem), .res_ready(res_ready)
  );

  always #5 clk = ~clk;

  // Reducer model: sees Start rise, then fall, clears for one cycle, then folds NCH chunks.
  int         rph;
  int         rcnt;
  logic [2:0] racc;
  logic [2:0] rrem;
  logic       hold_busy;

  function automatic logic [2:0] rstep(logic [2:0] a, logic [CW-1:0] b);
    return 3'((int'(a) * 64 + int'(b)) % 7);
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      rph <= 0; rcnt <= 0; racc <= '0; rrem <= '0;
    end else begin
      case (rph)
        0: if (ss_start) rph <= 1;
        1: if (!ss_start) rph <= 2;
        2: begin racc <= '0; rcnt <= 0; rph <= 3; end
        default: begin
          racc <= rstep(racc, ss_bus);
          rcnt <= rcnt + 1;
          if (rcnt == NCH - 1) begin
            rrem <= rstep(racc, ss_bus);
            rph  <= 0;
          end
        end
      endcase
    end
  end

  assign ss_ready = (rph == 0) && !hold_busy;
  assign ss_rem   = rrem;

  // Offer d, wait for accept (cycle 0), then check cycles 1..13. Returns at the cycle-13 negedge.
  task automatic op(input logic [47:0] d, input logic [2:0] er, input bit hold,
                    output int waited);
    in_data  = d;
    in_valid = 1'b1;
    waited   = 0;
    while (!in_ready) begin
      if (waited >= 60) begin
        checks++; failures++;
        $display("FAIL accept_timeout: no accept within %0d cycles, required accept", waited);
        in_valid = 1'b0;
        waited = -1;
        return;
      end
      @(negedge clk);
      waited++;
    end
    for (int c = 1; c <= 13; c++) begin
      @(negedge clk);
      if (c == 1 && !hold) in_valid = 1'b0;
      checks++;
      if (ss_start !== (c == 1)) begin
        failures++;
        $display("FAIL ss_start_c%0d: got %b required %b", c, ss_start, (c == 1));
      end
      if (c >= 4 && c <= 11) obs_bus[c-4] = ss_bus;
      else begin
        checks++;
        if (ss_bus !== '0) begin
          failures++;
          $display("FAIL ss_bus_idle_c%0d: got %0d required 0", c, ss_bus);
        end
      end
      checks++;
      if (res_valid !== (c == 13)) begin
        failures++;
        $display("FAIL res_valid_c%0d: got %b required %b", c, res_valid, (c == 13));
      end
      if (c < 13) begin
        checks++;
        if (in_ready !== 1'b0) begin
          failures++;
          $display("FAIL in_ready_busy_c%0d: got %b required 0", c, in_ready);
        end
      end
    end
    checks++;
    if (res_rem !== er) begin
      failures++;
      $display("FAIL res_rem_%0h: got %0d required %0d", d, res_rem, er);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; in_valid = 1'b0; in_data = '0; res_ready = 1'b1; hold_busy = 1'b0;
    #2;
    checks++;
    if (ss_start !== 1'b0 || ss_bus !== '0 || res_valid !== 1'b0 || res_rem !== 3'd0) begin
      failures++;
      $display("FAIL reset_outputs: got start=%b bus=%0d valid=%b rem=%0d required all 0",
               ss_start, ss_bus, res_valid, res_rem);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_in_ready: got %b required 1", in_ready);
    end
    @(negedge clk); @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    int w;
    logic [CW-1:0] exp_bus [NCH];
    exp_bus = '{6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd1, 6'd36};
    op(48'd100, 3'd2, 1'b0, w);
    for (int i = 0; i < NCH; i++) begin
      checks++;
      if (obs_bus[i] !== exp_bus[i]) begin
        failures++;
        $display("FAIL chunk_%0d: got %0d required %0d", i, obs_bus[i], exp_bus[i]);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_values();
    int w;
    op(48'hFFFF_FFFF_FFFF, 3'd0, 1'b0, w); @(negedge clk);
    op(48'd6, 3'd6, 1'b0, w);              @(negedge clk);
    op(48'h0000_0000_0007, 3'd0, 1'b0, w); @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int w;
    op(48'd13, 3'd6, 1'b1, w);
    // Called at the cycle-13 negedge, so a one-cycle wait puts the second accept at cycle 14.
    op(48'd20, 3'd6, 1'b0, w);
    checks++;
    if (w !== 1) begin
      failures++;
      $display("FAIL b2b_interval: waited %0d cycles after cycle 13, required 1", w);
    end
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    int w;
    res_ready = 1'b0;
    op(48'd13, 3'd6, 1'b0, w);
    in_data = 48'd20; in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checks++;
      if (res_valid !== 1'b1 || res_rem !== 3'd6 || in_ready !== 1'b0) begin
        failures++;
        $display("FAIL bp_hold_%0d: got valid=%b rem=%0d in_ready=%b required 1/6/0",
                 i, res_valid, res_rem, in_ready);
      end
    end
    res_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      failures++;
      $display("FAIL bp_release_same_cycle: got in_ready=%b required 0", in_ready);
    end
    @(negedge clk);
    op(48'd20, 3'd6, 1'b0, w);
    checks++;
    if (w !== 0) begin
      failures++;
      $display("FAIL bp_accept_after_release: waited %0d required 0", w);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_midfeed();
    int w;
    in_data = 48'd100; in_valid = 1'b1;
    w = 0;
    while (!in_ready && w < 60) begin @(negedge clk); w++; end
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      if (c == 1) in_valid = 1'b0;
    end
    rst = 1'b0;
    #1;
    checks++;
    if (ss_start !== 1'b0 || ss_bus !== '0 || res_valid !== 1'b0 || res_rem !== 3'd0
        || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL midfeed_reset: got start=%b bus=%0d valid=%b rem=%0d in_ready=%b required 0/0/0/0/1",
               ss_start, ss_bus, res_valid, res_rem, in_ready);
    end
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      checks++;
      if (res_valid !== 1'b0 || ss_start !== 1'b0) begin
        failures++;
        $display("FAIL midfeed_no_result_%0d: got valid=%b start=%b required 0/0",
                 i, res_valid, ss_start);
      end
    end
    op(48'd100, 3'd2, 1'b0, w);
    @(negedge clk);
  endtask

  task automatic test_ss_busy();
    int w;
    hold_busy = 1'b1;
    in_data = 48'd6; in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b0 || ss_start !== 1'b0) begin
        failures++;
        $display("FAIL busy_hold_%0d: got in_ready=%b start=%b required 0/0", i, in_ready, ss_start);
      end
    end
    hold_busy = 1'b0;
    #1;
    op(48'd6, 3'd6, 1'b0, w);
    checks++;
    if (w !== 0) begin
      failures++;
      $display("FAIL busy_release_accept: waited %0d required 0", w);
    end
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not finish, required completion");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_basic();
    test_values();
    test_back_to_back();
    test_backpressure();
    test_reset_midfeed();
    test_ss_busy();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mod7_operand_feeder.md
# mod7_operand_feeder

Upstream companion to the serial mod-7 reducer. It accepts a 48-bit operand over a valid/ready handshake and drives the reducer's Start/6-bit-chunk interface with exact cycle alignment. It then captures the 3-bit remainder and presents it on a valid/ready result port. It sits between the operand source and the reducer and owns all sequencing of the reducer's input side.

## Interface
- `CW`, 6: chunk width; must equal the reducer's input bus width.
- `NCH`, 8: number of chunks per operand; must equal the reducer's iteration count.
- Operand width is `CW*NCH` (48 at defaults).

- `clk` in 1: single clock; all state updates on rising edge.
- `rst` in 1: reset, asynchronous and active-low (asserted when 0).
- `in_valid` in 1: operand offered.
- `in_data` in CW*NCH: operand; sampled only on accept.
- `in_ready` out 1: operand accepted on the cycle when `in_valid & in_ready`.
- `ss_ready` in 1: reducer Ready.
- `ss_rem` in 3: reducer result bus.
- `ss_start` out 1: reducer Start.
- `ss_bus` out CW: chunk presented to the reducer.
- `res_valid` out 1: remainder available.
- `res_rem` out 3: remainder; stable while `res_valid=1`.
- `res_ready` in 1: consumer takes the result when `res_valid & res_ready`.

## Operation
- FSM states: IDLE, START, GAP, LOAD, FEED, WAIT, RESULT.
- IDLE:
  - `in_ready = ss_ready`.
  - On accept: load `in_data` into shift register `sr`, clear chunk counter `cnt`, go to START.
- START: `ss_start=1` for exactly one cycle; go to GAP.
- GAP: `ss_start=0`; go to LOAD. The reducer sees Start fall here and moves to its clear state.
- LOAD: one cycle; the reducer clears its accumulator; go to FEED.
- FEED: NCH cycles.
  - `ss_bus = sr[CW*NCH-1 -: CW]` (MSB chunk first).
  - Each cycle, `sr <= sr << CW` and `cnt <= cnt+1`.
  - When `cnt == NCH-1`, go to WAIT.
- WAIT: one cycle; the reducer is back in idle. Capture `res_rem <= ss_rem` and go to RESULT.
- RESULT:
  - `res_valid=1`.
  - On `res_ready`, go to IDLE. This takes priority; no new operand is accepted in the same cycle.
- `ss_bus=0` in every state except FEED.
- `ss_start=1` only in START.
- `cnt` width is `$clog2(NCH)` and holds 0..NCH-1. It never wraps inside FEED.
- `in_ready=0` in every state except IDLE. An `in_valid` offered while busy is held off and not dropped.
- If `ss_ready=0` in IDLE (the reducer is busy for any reason), do not accept. Wait in IDLE.
- Reset (`rst=0`) at any time, including mid-FEED:
  - State goes to IDLE; `sr`, `cnt` and `res_rem` go to 0.
  - All outputs go to 0 except `in_ready`, which follows `ss_ready`.
  - Any in-flight operand is discarded and no result is produced for it.
  - The reducer shares the reset net through an inverter, so it also returns to idle.

## Timing
- Accept at cycle 0 gives: START at cycle 1, GAP at 2, LOAD at 3, FEED at 4..3+NCH (4..11), WAIT at 12, RESULT from 13.
- Latency from accept to `res_valid` is NCH+5 cycles (13).
- Minimum operand interval is NCH+6 cycles (14) when `res_ready` is held at 1.
- `res_valid` and `res_rem` remain stable until the result is taken. Backpressure stalls the feeder in RESULT indefinitely.

## Structure
- Shared package: FSM state enum `feeder_state_t`; constants `CW_DEF=6` and `NCH_DEF=8`.
- No sub-module; a single module holds the FSM, the shift register and the counter.
- The top-level integration that instantiates this block with the reducer is outside this block.

## Test plan
- Operand 100, `res_ready=1`:
  - `ss_start` is high exactly at cycle 1.
  - `ss_bus` shows chunks 0,0,0,0,0,0,1,36 in cycles 4..11.
  - `res_valid` rises at cycle 13 with `res_rem=2`.
- Operand 2^48-1 gives `res_rem=0`; operand 6 gives 6; operand 48'h0000_0000_0007 gives 0.
- Back-to-back operands 13 then 20 with `in_valid` held: second accept occurs at cycle 14; results 6 then 6.
- Hold `res_ready=0` for 20 cycles after the first result:
  - `res_valid` and `res_rem` stay stable.
  - `in_ready` stays 0.
  - The next accept occurs only after `res_ready` is asserted.
- Pull `rst` low at cycle 7 (mid-FEED):
  - All outputs return to their reset values immediately, with no result for that operand.
  - After release, a new operand 100 yields 2 with normal timing.
- Tie `ss_ready=0`: no accept occurs despite `in_valid=1`. Release it and the accept happens the same cycle.
